// File: rtl/ps2_kbd_ctrl_if.sv
// Handshake bundle between the keyboard controller and the PS/2 rx/tx engines,
// LED requester and scan-code consumer.
interface ps2_kbd_ctrl_if;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [7:0] tx_byte;
    logic       tx_send;
    logic       tx_done;
    logic       tx_error;
    logic       led_req;
    logic [2:0] led_mask;
    logic       led_done;
    logic       kbd_ready;
    logic       kbd_error;
    logic [7:0] scan_byte;
    logic       scan_valid;

    modport master (
        input  rx_byte, rx_valid, tx_done, tx_error, led_req, led_mask,
        output tx_byte, tx_send, led_done, kbd_ready, kbd_error, scan_byte, scan_valid
    );

    modport slave (
        output rx_byte, rx_valid, tx_done, tx_error, led_req, led_mask,
        input  tx_byte, tx_send, led_done, kbd_ready, kbd_error, scan_byte, scan_valid
    );
endinterface

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard controller: reset/self-test bring-up, LED update command
// sequence with resend/timeout retries, and scan-code forwarding while idle.
module ps2_kbd_ctrl #(
    parameter int ACK_TIMEOUT = 1000000,
    parameter int BAT_TIMEOUT = 50000000,
    parameter int MAX_RETRY   = 3
) (
    input logic          clk,
    input logic          rst,
    ps2_kbd_ctrl_if.master bus
);

    localparam int TMAX   = (ACK_TIMEOUT > BAT_TIMEOUT) ? ACK_TIMEOUT : BAT_TIMEOUT;
    localparam int TW_RAW = $clog2(TMAX);
    localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;
    localparam int RW_RAW = $clog2(MAX_RETRY + 1);
    localparam int RW     = (RW_RAW < 2) ? 2 : RW_RAW;

    typedef enum logic [3:0] {
        RST_TX, RST_ACK, BAT_WAIT, IDLE, CMD_TX, CMD_ACK, DAT_TX, DAT_ACK, ERROR
    } state_t;

    state_t          state, next_state;
    logic [TW-1:0]   timer;
    logic [RW-1:0]   retry_cnt;
    logic [2:0]      led_latched;
    logic            tx_first;

    logic            load_tx, inc_retry, clr_retry, load_led, fail;
    logic            timeout, rx_ack, rx_resend;

    // A failed attempt from either half of an exchange resends from the TX state.
    function automatic state_t tx_of(input state_t s);
        case (s)
            RST_TX, RST_ACK: tx_of = RST_TX;
            CMD_TX, CMD_ACK: tx_of = CMD_TX;
            DAT_TX, DAT_ACK: tx_of = DAT_TX;
            default:         tx_of = ERROR;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RST_TX;
            timer       <= '0;
            retry_cnt   <= '0;
            led_latched <= 3'b000;
            tx_first    <= 1'b1;
        end else begin
            state    <= next_state;
            tx_first <= load_tx;
            if (next_state != state)
                timer <= '0;
            else
                timer <= timer + 1'b1;
            if (clr_retry)
                retry_cnt <= '0;
            else if (inc_retry)
                retry_cnt <= retry_cnt + 1'b1;
            if (load_led)
                led_latched <= bus.led_mask;
        end
    end

    assign rx_ack    = bus.rx_valid && (bus.rx_byte == 8'hFA);
    assign rx_resend = bus.rx_valid && (bus.rx_byte == 8'hFE);
    assign timeout   = (state == BAT_WAIT) ? (timer == TW'(BAT_TIMEOUT - 1))
                                           : (timer == TW'(ACK_TIMEOUT - 1));

    always_comb begin
        next_state = state;
        load_tx    = 1'b0;
        inc_retry  = 1'b0;
        clr_retry  = 1'b0;
        load_led   = 1'b0;
        fail       = 1'b0;

        case (state)
            RST_TX, CMD_TX, DAT_TX: begin
                if (bus.tx_done) begin
                    case (state)
                        RST_TX:  next_state = RST_ACK;
                        CMD_TX:  next_state = CMD_ACK;
                        default: next_state = DAT_ACK;
                    endcase
                end else if (bus.tx_error) begin
                    fail = 1'b1;
                end
            end
            RST_ACK, CMD_ACK, DAT_ACK: begin
                if (rx_ack) begin
                    clr_retry = 1'b1;
                    case (state)
                        RST_ACK: next_state = BAT_WAIT;
                        CMD_ACK: begin
                            next_state = DAT_TX;
                            load_tx    = 1'b1;
                        end
                        default: next_state = IDLE;
                    endcase
                end else if (rx_resend || timeout) begin
                    fail = 1'b1;
                end
            end
            BAT_WAIT: begin
                if (bus.rx_valid && bus.rx_byte == 8'hAA) begin
                    next_state = IDLE;
                    clr_retry  = 1'b1;
                end else if (bus.rx_valid && (bus.rx_byte == 8'hFC || bus.rx_byte == 8'hFD)) begin
                    next_state = ERROR;
                end else if (timeout) begin
                    next_state = ERROR;
                end
            end
            IDLE: begin
                if (bus.led_req) begin
                    load_led   = 1'b1;
                    next_state = CMD_TX;
                    load_tx    = 1'b1;
                end
            end
            ERROR:   next_state = ERROR;
            default: next_state = RST_TX;
        endcase

        if (fail) begin
            if (retry_cnt < RW'(MAX_RETRY)) begin
                next_state = tx_of(state);
                inc_retry  = 1'b1;
                load_tx    = 1'b1;
            end else begin
                next_state = ERROR;
            end
        end
    end

    // tx_byte is decoded from the state so it stays put until the engine answers.
    always_comb begin
        bus.tx_byte = 8'h00;
        if (!rst) begin
            case (state)
                RST_TX:  bus.tx_byte = 8'hFF;
                CMD_TX:  bus.tx_byte = 8'hED;
                DAT_TX:  bus.tx_byte = {5'b00000, led_latched};
                default: bus.tx_byte = 8'h00;
            endcase
        end
    end

    assign bus.tx_send    = tx_first && !rst;
    assign bus.led_done   = !rst && (state == DAT_ACK) && rx_ack;
    assign bus.kbd_ready  = (state == IDLE);
    assign bus.kbd_error  = (state == ERROR);
    assign bus.scan_byte  = bus.rx_byte;
    assign bus.scan_valid = bus.rx_valid && (state == IDLE);

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Self-checking bench for ps2_kbd_ctrl: directed bring-up/LED/retry/BAT/reset
// scenarios with literal expectations, then randomized traffic against a
// transaction-level keyboard-protocol model checked every cycle.
module tb_ps2_kbd_ctrl;

    localparam int ACK_T = 100;
    localparam int BAT_T = 500;
    localparam int MAXR  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_kbd_ctrl_if bus ();

    ps2_kbd_ctrl #(.ACK_TIMEOUT(ACK_T), .BAT_TIMEOUT(BAT_T), .MAX_RETRY(MAXR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int checks = 0;
    int passed = 0;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual === expected)
            passed++;
        else
            $display("[TB] FAIL %s: got %h, wanted %h at %0t", name, actual, expected, $time);
    endtask

    // ---------------- behavioural model ----------------
    // What the controller is doing, in protocol terms: which command is
    // outstanding, and whether we are waiting on the line or on the keyboard.
    typedef enum int { SEND, AWAIT, BOOT, READY, DEAD } phase_t;
    typedef enum int { CMD_RESET, CMD_LED, CMD_LEDDATA } cmd_t;

    phase_t   m_phase;
    cmd_t     m_cmd;
    logic     m_fresh;
    int       m_fails;
    int       m_wait;
    logic [2:0] m_mask;
    logic     m_known = 1'b0;

    function automatic logic [7:0] cmd_byte();
        case (m_cmd)
            CMD_RESET: cmd_byte = 8'hFF;
            CMD_LED:   cmd_byte = 8'hED;
            default:   cmd_byte = {5'b0, m_mask};
        endcase
    endfunction

    task automatic model_fail();
        if (m_fails < MAXR) begin
            m_fails++;
            m_phase = SEND;
            m_fresh = 1'b1;
        end else begin
            m_phase = DEAD;
        end
    endtask

    // Compare on the falling edge (inputs are stable then), then advance the
    // model to where the next rising edge will leave the controller.
    always @(negedge clk) begin
        if (rst) begin
            checkOutput("rst_tx_send", {7'b0, bus.tx_send}, 8'h00);
            checkOutput("rst_tx_byte", bus.tx_byte, 8'h00);
            checkOutput("rst_led_done", {7'b0, bus.led_done}, 8'h00);
            m_phase = SEND; m_cmd = CMD_RESET; m_fresh = 1'b1;
            m_fails = 0; m_wait = 0; m_mask = 3'b000; m_known = 1'b1;
        end else if (m_known) begin
            checkOutput("m_tx_send", {7'b0, bus.tx_send}, {7'b0, (m_phase == SEND) && m_fresh});
            if (m_phase == SEND)
                checkOutput("m_tx_byte", bus.tx_byte, cmd_byte());
            checkOutput("m_kbd_ready", {7'b0, bus.kbd_ready}, {7'b0, m_phase == READY});
            checkOutput("m_kbd_error", {7'b0, bus.kbd_error}, {7'b0, m_phase == DEAD});
            checkOutput("m_scan_valid", {7'b0, bus.scan_valid}, {7'b0, bus.rx_valid && m_phase == READY});
            if (bus.scan_valid && m_phase == READY)
                checkOutput("m_scan_byte", bus.scan_byte, bus.rx_byte);
            checkOutput("m_led_done", {7'b0, bus.led_done},
                        {7'b0, m_phase == AWAIT && m_cmd == CMD_LEDDATA && bus.rx_valid && bus.rx_byte == 8'hFA});

            case (m_phase)
                SEND: begin
                    m_fresh = 1'b0;
                    if (bus.tx_done) begin
                        m_phase = AWAIT; m_wait = 0;
                    end else if (bus.tx_error) begin
                        model_fail();
                    end
                end
                AWAIT: begin
                    if (bus.rx_valid && bus.rx_byte == 8'hFA) begin
                        m_fails = 0;
                        if (m_cmd == CMD_RESET) begin
                            m_phase = BOOT; m_wait = 0;
                        end else if (m_cmd == CMD_LED) begin
                            m_cmd = CMD_LEDDATA; m_phase = SEND; m_fresh = 1'b1;
                        end else begin
                            m_phase = READY;
                        end
                    end else if (bus.rx_valid && bus.rx_byte == 8'hFE) begin
                        model_fail();
                    end else if (m_wait == ACK_T - 1) begin
                        model_fail();
                    end else begin
                        m_wait++;
                    end
                end
                BOOT: begin
                    if (bus.rx_valid && bus.rx_byte == 8'hAA) begin
                        m_phase = READY; m_fails = 0;
                    end else if (bus.rx_valid && (bus.rx_byte == 8'hFC || bus.rx_byte == 8'hFD)) begin
                        m_phase = DEAD;
                    end else if (m_wait == BAT_T - 1) begin
                        m_phase = DEAD;
                    end else begin
                        m_wait++;
                    end
                end
                READY: begin
                    if (bus.led_req) begin
                        m_mask = bus.led_mask; m_cmd = CMD_LED;
                        m_phase = SEND; m_fresh = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_done();
        tick(); bus.tx_done = 1'b1; tick(); bus.tx_done = 1'b0;
    endtask

    task automatic pulse_err();
        tick(); bus.tx_error = 1'b1; tick(); bus.tx_error = 1'b0;
    endtask

    task automatic pulse_rx(input logic [7:0] b);
        tick(); bus.rx_byte = b; bus.rx_valid = 1'b1; tick(); bus.rx_valid = 1'b0;
    endtask

    task automatic pulse_led(input logic [2:0] m);
        tick(); bus.led_mask = m; bus.led_req = 1'b1; tick(); bus.led_req = 1'b0;
    endtask

    // Waits for the next tx_send and checks its byte; lat = falling edges waited.
    task automatic wait_send(input logic [7:0] b, input string name, input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (bus.tx_send) begin
                lat = i;
                checkOutput(name, bus.tx_byte, b);
                return;
            end
        end
        checks++;
        $display("[TB] FAIL %s: no tx_send within %0d cycles, wanted byte %h", name, budget, b);
    endtask

    task automatic wait_error(input string name, input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (bus.kbd_error) begin
                lat = i;
                return;
            end
        end
    endtask

    task automatic count_sends(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.tx_send) n++;
        end
    endtask

    task automatic do_reset();
        tick(); rst = 1'b1; tick(); tick(); rst = 1'b0;
    endtask

    task automatic bring_up();
        int lat;
        do_reset();
        wait_send(8'hFF, "boot_send_ff", 5, lat);
        pulse_done();
        pulse_rx(8'hFA);
        pulse_rx(8'hAA);
    endtask

    task automatic applyStimulus();
        int lat, n;

        // Bring-up: reset command, ack, self-test pass.
        bus.rx_byte = 8'h00; bus.rx_valid = 1'b0; bus.tx_done = 1'b0; bus.tx_error = 1'b0;
        bus.led_req = 1'b0; bus.led_mask = 3'b000;
        rst = 1'b1;
        tick(); tick();
        @(negedge clk);
        checkOutput("lit_rst_send", {7'b0, bus.tx_send}, 8'h00);
        tick(); rst = 1'b0;
        @(negedge clk);
        checkOutput("lit_first_send", {7'b0, bus.tx_send}, 8'h01);
        checkOutput("lit_first_byte", bus.tx_byte, 8'hFF);
        pulse_done();
        pulse_rx(8'hFA);
        pulse_rx(8'hAA);
        @(negedge clk);
        checkOutput("lit_ready", {7'b0, bus.kbd_ready}, 8'h01);
        count_sends(10, n);
        checkOutput("lit_idle_quiet", 8'(n), 8'd0);

        // LED update with mask 101.
        pulse_led(3'b101);
        wait_send(8'hED, "lit_led_cmd", 5, lat);
        pulse_done();
        pulse_rx(8'hFA);
        wait_send(8'h05, "lit_led_data", 5, lat);
        pulse_done();
        tick(); bus.rx_byte = 8'hFA; bus.rx_valid = 1'b1;
        @(negedge clk);
        checkOutput("lit_led_done", {7'b0, bus.led_done}, 8'h01);
        tick(); bus.rx_valid = 1'b0;
        @(negedge clk);
        checkOutput("lit_led_done_once", {7'b0, bus.led_done}, 8'h00);
        checkOutput("lit_ready_after_led", {7'b0, bus.kbd_ready}, 8'h01);

        // Scan-code forwarding and filtering.
        tick(); bus.rx_byte = 8'h1C; bus.rx_valid = 1'b1;
        @(negedge clk);
        checkOutput("lit_scan_valid", {7'b0, bus.scan_valid}, 8'h01);
        checkOutput("lit_scan_byte", bus.scan_byte, 8'h1C);
        tick(); bus.rx_valid = 1'b0;
        pulse_led(3'b010);
        wait_send(8'hED, "lit_filter_cmd", 5, lat);
        pulse_done();
        tick(); bus.rx_byte = 8'h1C; bus.rx_valid = 1'b1;
        @(negedge clk);
        checkOutput("lit_scan_blocked", {7'b0, bus.scan_valid}, 8'h00);
        tick(); bus.rx_valid = 1'b0;
        pulse_rx(8'hFA);
        wait_send(8'h02, "lit_filter_data", 5, lat);
        pulse_done();
        pulse_led(3'b111);
        pulse_rx(8'hFA);
        count_sends(20, n);
        checkOutput("lit_led_req_dropped", 8'(n), 8'd0);

        // Resend, timeout, tx error, then the fourth failure goes to ERROR.
        pulse_led(3'b001);
        wait_send(8'hED, "lit_retry_cmd", 5, lat);
        pulse_done();
        pulse_rx(8'hFE);
        wait_send(8'hED, "lit_resend_fe", 5, lat);
        checkOutput("lit_resend_latency", 8'(lat), 8'd1);
        pulse_done();
        wait_send(8'hED, "lit_resend_timeout", ACK_T + 20, lat);
        checkOutput("lit_timeout_latency", 8'(lat), 8'd101);
        pulse_err();
        wait_send(8'hED, "lit_resend_txerr", 5, lat);
        @(negedge clk);
        checkOutput("lit_not_error_yet", {7'b0, bus.kbd_error}, 8'h00);
        pulse_done();
        pulse_rx(8'hFE);
        @(negedge clk);
        checkOutput("lit_retry_exhausted", {7'b0, bus.kbd_error}, 8'h01);

        // Self-test failure code, then self-test silence.
        do_reset();
        wait_send(8'hFF, "lit_bat_ff", 5, lat);
        pulse_done();
        pulse_rx(8'hFA);
        pulse_rx(8'hFC);
        @(negedge clk);
        checkOutput("lit_bat_fc", {7'b0, bus.kbd_error}, 8'h01);
        do_reset();
        wait_send(8'hFF, "lit_bat_ff2", 5, lat);
        pulse_done();
        pulse_rx(8'hFA);
        wait_error("bat_timeout", BAT_T + 20, lat);
        checkOutput("lit_bat_timeout_latency", 8'(lat - 400), 8'd101);

        // Reset in DAT_ACK with one retry already spent.
        bring_up();
        pulse_led(3'b100);
        wait_send(8'hED, "lit_mid_cmd", 5, lat);
        pulse_done();
        pulse_rx(8'hFA);
        wait_send(8'h04, "lit_mid_data", 5, lat);
        pulse_done();
        pulse_rx(8'hFE);
        wait_send(8'h04, "lit_mid_resend", 5, lat);
        pulse_done();
        tick(); rst = 1'b1; bus.rx_byte = 8'hFA; bus.rx_valid = 1'b1;
        @(negedge clk);
        checkOutput("lit_mid_no_led_done", {7'b0, bus.led_done}, 8'h00);
        tick(); rst = 1'b0; bus.rx_valid = 1'b0;
        wait_send(8'hFF, "lit_mid_ff", 5, lat);
        checkOutput("lit_mid_ff_latency", 8'(lat), 8'd1);
        for (int i = 0; i < MAXR; i++) begin
            pulse_err();
            wait_send(8'hFF, "lit_mid_retry", 5, lat);
        end
        @(negedge clk);
        checkOutput("lit_mid_retry_cleared", {7'b0, bus.kbd_error}, 8'h00);
        pulse_err();
        @(negedge clk);
        checkOutput("lit_mid_fourth_fail", {7'b0, bus.kbd_error}, 8'h01);

        // Randomized traffic; quiet stretches let the timeouts fire.
        do_reset();
        for (int c = 0; c < 24000; c++) begin
            int pick;
            logic quiet;
            tick();
            quiet = ((c / 700) % 4) == 3;
            rst = ($urandom_range(0, 399) == 0);
            bus.rx_valid = !quiet && ($urandom_range(0, 7) == 0);
            pick = $urandom_range(0, 99);
            if (pick < 40)      bus.rx_byte = 8'hFA;
            else if (pick < 50) bus.rx_byte = 8'hFE;
            else if (pick < 75) bus.rx_byte = 8'hAA;
            else if (pick < 78) bus.rx_byte = 8'hFC;
            else if (pick < 80) bus.rx_byte = 8'hFD;
            else if (pick < 90) bus.rx_byte = 8'h1C;
            else                bus.rx_byte = 8'($urandom);
            bus.tx_done  = ($urandom_range(0, 9) == 0);
            bus.tx_error = ($urandom_range(0, 39) == 0);
            bus.led_req  = ($urandom_range(0, 29) == 0);
            bus.led_mask = 3'($urandom);
        end
        tick();
        rst = 1'b0; bus.rx_valid = 1'b0; bus.tx_done = 1'b0; bus.tx_error = 1'b0; bus.led_req = 1'b0;
        tick(); tick();
    endtask

    initial begin
        applyStimulus();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
